proc_core: RTL and testbench
============================

# proc_core

Parametrised single-issue processor core with external instruction ROM and data memory ports. Successor to the fixed 8-bit/12-bit-PC top level, which stops only when the PC reaches a fixed address. This core adds:
- a start/done handshake FSM and an explicit HALT instruction;
- a registered zero flag driving relative branches;
- a stall state for synchronous-read loads;
- a cycle counter with watchdog timeout.

It sits between instr_ROM and dat_mem in the top level.

## Interface
Parameters:
- D, 12, program counter width
- W, 8, data/register width (W >= 6)
- START_ADDR, 0, PC value loaded on launch
- CW, 16, cycle counter width
- TIMEOUT, 0, watchdog limit in cycles; 0 disables

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  launch request, sampled in IDLE/DONE
- done  out  1  high in DONE state
- timeout  out  1  high in DONE if the watchdog ended the run
- imem_addr  out  D  current PC
- imem_data  in  9  instruction word, combinational from imem_addr
- dmem_addr  out  W  data address (= R[rB])
- dmem_wdata  out  W  store data (= R[rA])
- dmem_we  out  1  store strobe
- dmem_rdata  in  W  load data, valid one cycle after address
- cycle_count  out  CW  cycles spent in RUN/MEM since launch

## Operation
- State: 8 x W register file R0..R7, PC (D bits), zero flag Z, FSM {IDLE, RUN, MEM, DONE}.
- Instruction fields: op = [8:6], rB = [5:3], rA = [2:0].
- Opcodes:
  - 000 ADD, R[rA] = R[rA] + R[rB]
  - 001 SUB, R[rA] = R[rA] - R[rB]
  - 010 AND
  - 011 XOR
  - 100 LDI, R0 = zero-extended [5:0]
  - 101 LD, R[rA] = mem[R[rB]]
  - 110 ST, mem[R[rB]] = R[rA]
  - 111 control, sub-op [5:4] with 4-bit signed offset off = [3:0]:
    - 00 BZ, PC = PC + sext(off) if Z
    - 01 BNZ, PC = PC + sext(off) if !Z
    - 10 JMP, PC = PC + sext(off)
    - 11 HALT
- Arithmetic and PC:
  - Results are modulo 2^W; carry is discarded.
  - Z is updated only by ADD/SUB/AND/XOR: Z = (result == 0). All other instructions hold Z.
  - PC arithmetic is modulo 2^D. A non-branching instruction gives PC + 1, wrapping from 2^D-1 to 0.
- FSM transitions:
  - IDLE: start=1 -> PC = START_ADDR, cycle_count = 0, Z = 0, go RUN. Registers are not cleared.
  - RUN: execute one instruction per cycle.
    - LD drives dmem_addr and goes to MEM; PC is held.
    - HALT goes to DONE; PC stays on the HALT address.
    - Everything else stays in RUN.
  - MEM: R[rA] = dmem_rdata, PC = PC + 1, return to RUN.
  - DONE: done = 1. start=1 relaunches exactly as from IDLE and clears timeout.
- start is ignored in RUN and MEM.
- Watchdog:
  - Applies when TIMEOUT != 0 and the FSM is in RUN or MEM with cycle_count == TIMEOUT.
  - No instruction retires that cycle; no register, memory or PC update occurs.
  - Next state is DONE with timeout = 1.
- cycle_count increments on every RUN/MEM cycle and saturates at 2^CW-1. It holds in IDLE/DONE.
- Reset (at any time, including mid-load), next edge:
  - FSM = IDLE; PC = START_ADDR; R0..R7 = 0; Z = 0.
  - cycle_count = 0; done = 0; timeout = 0; dmem_we = 0.
  - A pending load is discarded.

## Timing
- Outputs after reset: done 0, timeout 0, dmem_we 0, cycle_count 0, imem_addr START_ADDR, dmem_addr 0, dmem_wdata 0.
- Launch: start high at edge N puts the FSM in RUN from N+1; the first instruction retires at edge N+2.
- Latency:
  - ALU, LDI, ST, branch and HALT take 1 cycle.
  - LD takes 2 cycles (RUN + MEM).
- ST: dmem_we is asserted combinationally only in a RUN cycle decoding ST; the write lands at that edge.
- dmem_we is 0 in IDLE, MEM, DONE and on a watchdog cycle.
- done rises the edge after HALT retires (or after the watchdog fires). It stays high until relaunch or reset.
- A branch reads Z as registered before its own cycle. A branch immediately after an ALU op sees that op's Z.

## Test plan
- Arithmetic:
  - Program: LDI 5; ADD R1,R0; SUB R1,R0; BZ +2; LDI 63; HALT.
  - Required: R1 = 0, Z = 1, branch taken, R0 stays 5, done = 1, cycle_count = 5.
- Memory:
  - Program: LDI 9; ST mem[R0] = R0; LD R2 = mem[R0]; HALT.
  - Required: dmem_we high for exactly 1 cycle with addr 9 and data 9; LD stalls 1 cycle; R2 = 9; cycle_count = 5.
- Wrap-around:
  - With W = 8: R1 = 255, R2 = 1, ADD R1,R2.
  - Required: R1 = 0, Z = 1.
  - With D = 4 and START_ADDR = 15: non-branch instruction -> next PC = 0.
- Watchdog:
  - TIMEOUT = 4 with the loop JMP 0.
  - Required: done and timeout rise after 4 RUN cycles; cycle_count = 4; start then relaunches with timeout = 0.
- Reset mid-operation:
  - reset asserted in the MEM cycle of an LD.
  - Required: destination register not written; all outputs at reset values next cycle; start is ignored while reset is high.
- Handshake:
  - Pulse start during RUN: ignored.
  - After HALT, start high in DONE: PC = START_ADDR, cycle_count = 0, registers retained.

Source files
------------

// File: rtl/proc_core.sv
`default_nettype none
// ============================================================================
// Module      : proc_core
// Description : Single-issue 9-bit-instruction core with start/done handshake,
//               zero-flag branches, load stall state and cycle watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_core #(
    parameter int D          = 12,
    parameter int W          = 8,
    parameter int START_ADDR = 0,
    parameter int CW         = 16,
    parameter int TIMEOUT    = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic          timeout,
    output logic [D-1:0]  imem_addr,
    input  logic [8:0]    imem_data,
    output logic [W-1:0]  dmem_addr,
    output logic [W-1:0]  dmem_wdata,
    output logic          dmem_we,
    input  logic [W-1:0]  dmem_rdata,
    output logic [CW-1:0] cycle_count
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_MEM  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_AND = 3'd2;
    localparam logic [2:0] c_OP_XOR = 3'd3;
    localparam logic [2:0] c_OP_LDI = 3'd4;
    localparam logic [2:0] c_OP_LD  = 3'd5;
    localparam logic [2:0] c_OP_ST  = 3'd6;
    localparam logic [2:0] c_OP_CTL = 3'd7;

    localparam logic [1:0] c_CT_BZ   = 2'd0;
    localparam logic [1:0] c_CT_BNZ  = 2'd1;
    localparam logic [1:0] c_CT_JMP  = 2'd2;
    localparam logic [1:0] c_CT_HALT = 2'd3;

    localparam logic [D-1:0]  c_START   = D'(START_ADDR);
    localparam logic [CW-1:0] c_TIMEOUT = CW'(TIMEOUT);
    localparam bit            c_WD_EN   = (TIMEOUT != 0);

    logic [1:0]    r_state;
    logic [D-1:0]  r_pc;
    logic [W-1:0]  r_regs [8];
    logic          r_z;
    logic [CW-1:0] r_cycles;
    logic          r_timeout;

    logic [2:0]    w_op;
    logic [2:0]    w_rb;
    logic [2:0]    w_ra;
    logic [1:0]    w_sub;
    logic [3:0]    w_off;
    logic [W-1:0]  w_va;
    logic [W-1:0]  w_vb;
    logic [W-1:0]  w_alu;
    logic          w_is_alu;
    logic          w_wd;
    logic [D-1:0]  w_pc_inc;
    logic [D-1:0]  w_pc_br;
    logic [D-1:0]  w_pc_next;
    logic [CW-1:0] w_cyc_next;

    assign w_op  = imem_data[8:6];
    assign w_rb  = imem_data[5:3];
    assign w_ra  = imem_data[2:0];
    assign w_sub = imem_data[5:4];
    assign w_off = imem_data[3:0];

    assign w_va     = r_regs[w_ra];
    assign w_vb     = r_regs[w_rb];
    assign w_is_alu = ~w_op[2];

    // Watchdog cycle: nothing retires, the run is simply cut off.
    assign w_wd = c_WD_EN && ((r_state == c_ST_RUN) || (r_state == c_ST_MEM))
                  && (r_cycles == c_TIMEOUT);

    assign w_pc_inc   = r_pc + D'(1);
    assign w_pc_br    = r_pc + D'($signed(w_off));
    assign w_cyc_next = (&r_cycles) ? r_cycles : r_cycles + CW'(1);

    always_comb begin
        w_alu = '0;
        case (w_op)
            c_OP_ADD: w_alu = w_va + w_vb;
            c_OP_SUB: w_alu = w_va - w_vb;
            c_OP_AND: w_alu = w_va & w_vb;
            c_OP_XOR: w_alu = w_va ^ w_vb;
            default:  w_alu = '0;
        endcase
    end

    always_comb begin
        w_pc_next = w_pc_inc;
        if (w_op == c_OP_LD) begin
            w_pc_next = r_pc;
        end else if (w_op == c_OP_CTL) begin
            case (w_sub)
                c_CT_BZ:  w_pc_next = r_z ? w_pc_br : w_pc_inc;
                c_CT_BNZ: w_pc_next = r_z ? w_pc_inc : w_pc_br;
                c_CT_JMP: w_pc_next = w_pc_br;
                default:  w_pc_next = r_pc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_pc      <= c_START;
            r_z       <= 1'b0;
            r_cycles  <= '0;
            r_timeout <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        r_state   <= c_ST_RUN;
                        r_pc      <= c_START;
                        r_cycles  <= '0;
                        r_z       <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                c_ST_RUN: begin
                    if (w_wd) begin
                        r_state   <= c_ST_DONE;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cycles <= w_cyc_next;
                        r_pc     <= w_pc_next;
                        if (w_is_alu) begin
                            r_regs[w_ra] <= w_alu;
                            r_z          <= (w_alu == '0);
                        end else if (w_op == c_OP_LDI) begin
                            r_regs[0] <= W'(imem_data[5:0]);
                        end
                        if (w_op == c_OP_LD) begin
                            r_state <= c_ST_MEM;
                        end else if ((w_op == c_OP_CTL) && (w_sub == c_CT_HALT)) begin
                            r_state <= c_ST_DONE;
                        end
                    end
                end
                c_ST_MEM: begin
                    if (w_wd) begin
                        r_state   <= c_ST_DONE;
                        r_timeout <= 1'b1;
                    end else begin
                        // PC was held on the LD, so imem_data still names rA.
                        r_regs[w_ra] <= dmem_rdata;
                        r_pc         <= w_pc_inc;
                        r_cycles     <= w_cyc_next;
                        r_state      <= c_ST_RUN;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign done        = (r_state == c_ST_DONE);
    assign timeout     = r_timeout;
    assign imem_addr   = r_pc;
    assign dmem_addr   = w_vb;
    assign dmem_wdata  = w_va;
    assign dmem_we     = (r_state == c_ST_RUN) && (w_op == c_OP_ST) && !w_wd;
    assign cycle_count = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_proc_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_core
// Description : Self-checking bench for proc_core: directed programs, ALU
//               vector table and random programs against an ISA model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_core;

    localparam logic [8:0] c_HALT = 9'h1F0;
    localparam logic [8:0] c_JMP0 = 9'h1E0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        r_reset, r_start_a, r_start_b, r_mem_init;
    logic        w_done_a, w_to_a, w_da_we;
    logic [11:0] w_ia_addr;
    logic [8:0]  w_ia_data;
    logic [7:0]  w_da_addr, w_da_wdata, r_da_rdata;
    logic [15:0] w_cc_a;
    logic        w_done_b, w_to_b, w_db_we;
    logic [3:0]  w_ib_addr;
    logic [8:0]  w_ib_data;
    logic [7:0]  w_db_addr, w_db_wdata, w_db_rdata;
    logic [15:0] w_cc_b;

    logic [8:0]  rom_a [4096];
    logic [8:0]  rom_b [16];
    logic [7:0]  mem_a [256];
    logic [7:0]  init_img [256];

    assign w_ia_data  = rom_a[w_ia_addr];
    assign w_ib_data  = rom_b[w_ib_addr];
    assign w_db_rdata = 8'h00;

    proc_core dut_a (
        .clk(clk), .reset(r_reset), .start(r_start_a), .done(w_done_a),
        .timeout(w_to_a), .imem_addr(w_ia_addr), .imem_data(w_ia_data),
        .dmem_addr(w_da_addr), .dmem_wdata(w_da_wdata), .dmem_we(w_da_we),
        .dmem_rdata(r_da_rdata), .cycle_count(w_cc_a)
    );

    proc_core #(.D(4), .W(8), .START_ADDR(15), .CW(16), .TIMEOUT(4)) dut_b (
        .clk(clk), .reset(r_reset), .start(r_start_b), .done(w_done_b),
        .timeout(w_to_b), .imem_addr(w_ib_addr), .imem_data(w_ib_data),
        .dmem_addr(w_db_addr), .dmem_wdata(w_db_wdata), .dmem_we(w_db_we),
        .dmem_rdata(w_db_rdata), .cycle_count(w_cc_b)
    );

    // Synchronous-read data memory with a one-cycle bulk preload.
    always @(posedge clk) begin
        if (r_mem_init) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= init_img[i];
        end else if (w_da_we) begin
            mem_a[w_da_addr] <= w_da_wdata;
        end
        r_da_rdata <= mem_a[w_da_addr];
    end

    int         we_cnt = 0;
    logic [7:0] we_addr_l = 8'h00, we_data_l = 8'h00;
    always @(negedge clk) begin
        if (w_da_we) begin
            we_cnt    = we_cnt + 1;
            we_addr_l = w_da_addr;
            we_data_l = w_da_wdata;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [8:0] enc(input logic [2:0] op, input logic [2:0] rb,
                                       input logic [2:0] ra);
        return {op, rb, ra};
    endfunction

    function automatic logic [8:0] ldi(input logic [5:0] imm);
        return {3'b100, imm};
    endfunction

    function automatic logic [8:0] br(input logic [1:0] sub, input logic [3:0] off);
        return {3'b111, sub, off};
    endfunction

    task automatic do_reset();
        r_reset = 1'b1;
        repeat (2) @(negedge clk);
        r_reset = 1'b0;
    endtask

    task automatic pulse_mem_init();
        r_mem_init = 1'b1;
        @(negedge clk);
        r_mem_init = 1'b0;
    endtask

    task automatic launch(input int which);
        if (which == 0) r_start_a = 1'b1; else r_start_b = 1'b1;
        @(negedge clk);
        r_start_a = 1'b0;
        r_start_b = 1'b0;
    endtask

    task automatic wait_done(input int which, input int budget, output int lat);
        lat = 0;
        while (((which == 0) ? !w_done_a : !w_done_b) && (lat < budget)) begin
            @(negedge clk);
            lat++;
        end
        check((which == 0) ? "done_a" : "done_b",
              int'((which == 0) ? w_done_a : w_done_b), 1);
    endtask

    // ISA-level reference: interprets rom_a from PC 0 starting with zeroed registers.
    int m_r [8];
    int m_mem [256];
    int m_z, m_cyc;

    task automatic model_run();
        int pc, op, ra, rb, off, res, steps;
        logic [8:0] ins;
        bit fin;
        for (int i = 0; i < 8; i++) m_r[i] = 0;
        for (int i = 0; i < 256; i++) m_mem[i] = int'(init_img[i]);
        m_z = 0; m_cyc = 0; pc = 0; fin = 0; steps = 0;
        while (!fin && steps < 1000) begin
            ins = rom_a[pc];
            op = int'(ins[8:6]); rb = int'(ins[5:3]); ra = int'(ins[2:0]);
            off = int'(ins[3:0]);
            if (off > 7) off = off - 16;
            steps++;
            m_cyc++;
            case (op)
                0, 1, 2, 3: begin
                    if (op == 0)      res = (m_r[ra] + m_r[rb]) % 256;
                    else if (op == 1) res = (m_r[ra] - m_r[rb] + 256) % 256;
                    else if (op == 2) res = m_r[ra] & m_r[rb];
                    else              res = m_r[ra] ^ m_r[rb];
                    m_r[ra] = res;
                    m_z = (res == 0) ? 1 : 0;
                    pc = pc + 1;
                end
                4: begin m_r[0] = int'(ins[5:0]); pc = pc + 1; end
                5: begin m_r[ra] = m_mem[m_r[rb]]; m_cyc++; pc = pc + 1; end
                6: begin m_mem[m_r[rb]] = m_r[ra]; pc = pc + 1; end
                default: begin
                    case (int'(ins[5:4]))
                        0: pc = (m_z != 0) ? pc + off : pc + 1;
                        1: pc = (m_z == 0) ? pc + off : pc + 1;
                        2: pc = pc + off;
                        default: fin = 1;
                    endcase
                end
            endcase
            pc = (pc + 4096) % 4096;
        end
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       z;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int lat, we0, nmis;

        vecs[0] = '{3'd0, 8'd255, 8'd1,   8'd0,   1'b1};
        vecs[1] = '{3'd0, 8'd100, 8'd27,  8'd127, 1'b0};
        vecs[2] = '{3'd0, 8'd200, 8'd100, 8'd44,  1'b0};
        vecs[3] = '{3'd1, 8'd5,   8'd5,   8'd0,   1'b1};
        vecs[4] = '{3'd1, 8'd3,   8'd5,   8'd254, 1'b0};
        vecs[5] = '{3'd2, 8'hF0,  8'h0F,  8'h00,  1'b1};
        vecs[6] = '{3'd2, 8'hAA,  8'hF3,  8'hA2,  1'b0};
        vecs[7] = '{3'd3, 8'h5A,  8'h5A,  8'h00,  1'b1};
        vecs[8] = '{3'd3, 8'h5A,  8'hFF,  8'hA5,  1'b0};

        r_reset = 1'b1; r_start_a = 1'b0; r_start_b = 1'b0; r_mem_init = 1'b0;
        for (int i = 0; i < 4096; i++) rom_a[i] = c_HALT;
        for (int i = 0; i < 16; i++) rom_b[i] = c_HALT;
        for (int i = 0; i < 256; i++) init_img[i] = 8'h00;
        rom_b[15] = ldi(6'd3);
        rom_b[0]  = c_JMP0;
        rom_a[0] = ldi(6'd5);
        rom_a[1] = enc(3'd0, 3'd0, 3'd1);
        rom_a[2] = enc(3'd1, 3'd0, 3'd1);
        rom_a[3] = br(2'd0, 4'd2);
        rom_a[4] = ldi(6'd63);
        rom_a[5] = c_HALT;
        do_reset();
        pulse_mem_init();

        check("rst_done", int'(w_done_a), 0);
        check("rst_timeout", int'(w_to_a), 0);
        check("rst_we", int'(w_da_we), 0);
        check("rst_cc", int'(w_cc_a), 0);
        check("rst_pc", int'(w_ia_addr), 0);
        check("rst_daddr", int'(w_da_addr), 0);
        check("rst_wdata", int'(w_da_wdata), 0);
        check("rst_pc_b", int'(w_ib_addr), 15);
        check("rst_b_outs", int'({w_db_we, w_db_addr, w_db_wdata}), 0);

        // Arithmetic program, with a start pulse mid-run that must be ignored.
        launch(0);
        r_start_a = 1'b1;
        @(negedge clk);
        r_start_a = 1'b0;
        wait_done(0, 50, lat);
        check("arith_latency", lat + 1, 5);
        check("arith_r1", int'(dut_a.r_regs[1]), 0);
        check("arith_z", int'(dut_a.r_z), 1);
        check("arith_r0", int'(dut_a.r_regs[0]), 5);
        check("arith_cc", int'(w_cc_a), 5);
        check("arith_timeout", int'(w_to_a), 0);

        // Relaunch from DONE keeps registers, clears PC, count and Z.
        launch(0);
        check("relaunch_pc", int'(w_ia_addr), 0);
        check("relaunch_cc", int'(w_cc_a), 0);
        check("relaunch_done", int'(w_done_a), 0);
        check("relaunch_z", int'(dut_a.r_z), 0);
        check("relaunch_r0_kept", int'(dut_a.r_regs[0]), 5);
        wait_done(0, 50, lat);

        // Store then load the same address.
        rom_a[0] = ldi(6'd9);
        rom_a[1] = enc(3'd6, 3'd0, 3'd0);
        rom_a[2] = enc(3'd5, 3'd0, 3'd2);
        rom_a[3] = c_HALT;
        for (int i = 4; i < 6; i++) rom_a[i] = c_HALT;
        we0 = we_cnt;
        launch(0);
        wait_done(0, 50, lat);
        check("mem_latency", lat, 5);
        check("mem_we_count", we_cnt - we0, 1);
        check("mem_we_addr", int'(we_addr_l), 9);
        check("mem_we_data", int'(we_data_l), 9);
        check("mem_r2", int'(dut_a.r_regs[2]), 9);
        check("mem_cc", int'(w_cc_a), 5);

        // ALU vector table: operands loaded from memory, then one ALU op.
        rom_a[0] = ldi(6'd0);
        rom_a[1] = enc(3'd5, 3'd0, 3'd1);
        rom_a[2] = ldi(6'd1);
        rom_a[3] = enc(3'd5, 3'd0, 3'd2);
        rom_a[5] = c_HALT;
        for (int v = 0; v < 9; v++) begin
            rom_a[4] = enc(vecs[v].op, 3'd2, 3'd1);
            init_img[0] = vecs[v].a;
            init_img[1] = vecs[v].b;
            pulse_mem_init();
            launch(0);
            wait_done(0, 50, lat);
            check($sformatf("vec%0d_res", v), int'(dut_a.r_regs[1]), int'(vecs[v].res));
            check($sformatf("vec%0d_z", v), int'(dut_a.r_z), int'(vecs[v].z));
            check($sformatf("vec%0d_cc", v), int'(w_cc_a), 8);
        end

        // Reset during the MEM cycle of a load.
        rom_a[0] = ldi(6'd9);
        rom_a[1] = enc(3'd5, 3'd0, 3'd3);
        rom_a[2] = c_HALT;
        for (int i = 3; i < 6; i++) rom_a[i] = c_HALT;
        init_img[9] = 8'h5A;
        pulse_mem_init();
        launch(0);
        @(negedge clk);
        @(negedge clk);
        check("midload_pc_held", int'(w_ia_addr), 1);
        r_reset = 1'b1;
        r_start_a = 1'b1;
        @(negedge clk);
        check("midload_r3", int'(dut_a.r_regs[3]), 0);
        check("midload_done", int'(w_done_a), 0);
        check("midload_cc", int'(w_cc_a), 0);
        check("midload_pc", int'(w_ia_addr), 0);
        check("midload_outs", int'({w_to_a, w_da_we, w_da_addr, w_da_wdata}), 0);
        @(negedge clk);
        r_reset = 1'b0;
        r_start_a = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset_idle_cc", int'(w_cc_a), 0);
        check("post_reset_idle_pc", int'(w_ia_addr), 0);

        // Narrow PC wrap and watchdog on the second instance.
        launch(1);
        @(negedge clk);
        check("b_pc_wrap", int'(w_ib_addr), 0);
        wait_done(1, 50, lat);
        check("b_wd_latency", lat + 1, 5);
        check("b_timeout", int'(w_to_b), 1);
        check("b_cc", int'(w_cc_b), 4);
        check("b_r0", int'(dut_b.r_regs[0]), 3);
        launch(1);
        check("b_relaunch_timeout", int'(w_to_b), 0);
        check("b_relaunch_done", int'(w_done_b), 0);
        check("b_relaunch_pc", int'(w_ib_addr), 15);
        wait_done(1, 50, lat);
        check("b_timeout2", int'(w_to_b), 1);

        // Random forward-branching programs against the ISA model.
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 32; i++) rom_a[i] = c_HALT;
            for (int i = 0; i < 16; i++) begin
                int k;
                k = $urandom_range(0, 9);
                case (k)
                    4: rom_a[i] = ldi(6'($urandom));
                    5: rom_a[i] = enc(3'd5, 3'($urandom), 3'($urandom));
                    6: rom_a[i] = enc(3'd6, 3'($urandom), 3'($urandom));
                    7: rom_a[i] = br(2'($urandom_range(0, 2)), 4'($urandom_range(1, 7)));
                    default: rom_a[i] = enc(3'($urandom_range(0, 3)), 3'($urandom), 3'($urandom));
                endcase
            end
            for (int i = 0; i < 256; i++) init_img[i] = 8'($urandom);
            do_reset();
            pulse_mem_init();
            model_run();
            launch(0);
            wait_done(0, 100, lat);
            for (int i = 0; i < 8; i++)
                check($sformatf("rnd%0d_r%0d", t, i), int'(dut_a.r_regs[i]), m_r[i]);
            check($sformatf("rnd%0d_z", t), int'(dut_a.r_z), m_z);
            check($sformatf("rnd%0d_cc", t), int'(w_cc_a), m_cyc);
            nmis = 0;
            for (int i = 0; i < 256; i++)
                if (int'(mem_a[i]) != m_mem[i]) nmis++;
            check($sformatf("rnd%0d_mem_diffs", t), nmis, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
